// File: rtl/fifo_in_writer.sv
// Avalon-MM master that feeds the HPS input FIFO from a local valid/ready buffer,
// gated by a credit counter refreshed from the FIFO fill_level CSR. Stats ports: FIFO_IN_WRITER_STATS_EN.
module fifo_in_writer #(
  parameter int DATA_W        = 32,
  parameter int LBUF_DEPTH    = 4,
  parameter int FIFO_CAPACITY = 256,
  parameter int POLL_INTERVAL = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] fifo_writedata,
  output logic              fifo_write,
  output logic              fifo_address,
  input  logic              fifo_waitrequest,
  output logic [2:0]        csr_address,
  output logic              csr_read,
  output logic              csr_write,
  output logic [31:0]       csr_writedata,
  input  logic [31:0]       csr_readdata,
  output logic [8:0]        credit
`ifdef FIFO_IN_WRITER_STATS_EN
  ,
  output logic [31:0]       words_written,
  output logic [31:0]       stall_cycles
`endif
);

  localparam int PTR_W = $clog2(LBUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BO_W  = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam logic [31:0]      CAP_32   = 32'(FIFO_CAPACITY);
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(LBUF_DEPTH);
  localparam logic [BO_W-1:0]  BO_LAST  = BO_W'(POLL_INTERVAL - 1);

  typedef enum logic [2:0] {
    POLL_REQ  = 3'd0,
    POLL_WAIT = 3'd1,
    IDLE      = 3'd2,
    WRITE     = 3'd3,
    BACKOFF   = 3'd4
  } state_t;

  state_t            state_r;
  logic [DATA_W-1:0] mem_r [LBUF_DEPTH];
  logic [PTR_W-1:0]  wptr_r;
  logic [PTR_W-1:0]  rptr_r;
  logic [PTR_W-1:0]  rptr_nxt_s;
  logic [CNT_W-1:0]  count_r;
  logic [CNT_W-1:0]  count_nxt_s;
  logic [BO_W-1:0]   bo_cnt_r;
  logic              push_s;
  logic              pop_s;
  logic              more_s;
  logic [DATA_W-1:0] head_s;
  logic [DATA_W-1:0] next_head_s;
  logic [8:0]        poll_credit_s;

  assign fifo_address  = 1'b0;
  assign csr_address   = 3'd0;
  assign csr_write     = 1'b0;
  assign csr_writedata = 32'd0;

  assign push_s     = in_valid && in_ready;
  assign pop_s      = fifo_write && !fifo_waitrequest;
  assign rptr_nxt_s = rptr_r + 1'b1;
  assign head_s     = mem_r[rptr_r];

  // Buffer occupancy after this cycle's push/pop, plus the word that follows the head.
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + 1'b1;
      2'b01:   count_nxt_s = count_r - 1'b1;
      default: count_nxt_s = count_r;
    endcase
    // With a single entry left, the next head can only be the word arriving now.
    if (count_r > CNT_W'(1)) begin
      next_head_s = mem_r[rptr_nxt_s];
    end else begin
      next_head_s = in_data;
    end
    more_s = (count_r > CNT_W'(1)) || push_s;
  end

  // Free space in the HPS FIFO from the fill value, clamped at zero.
  always_comb begin
    if (csr_readdata >= CAP_32) begin
      poll_credit_s = 9'd0;
    end else begin
      poll_credit_s = 9'(CAP_32 - csr_readdata);
    end
  end

  // Local buffer storage; contents need no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wptr_r] <= in_data;
    end
  end

  // Local buffer pointers, occupancy and registered ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_r   <= '0;
      rptr_r   <= '0;
      count_r  <= '0;
      in_ready <= 1'b0;
    end else begin
      if (push_s) begin
        wptr_r <= wptr_r + 1'b1;
      end
      if (pop_s) begin
        rptr_r <= rptr_nxt_s;
      end
      count_r  <= count_nxt_s;
      in_ready <= (count_nxt_s != DEPTH_C);
    end
  end

  // Control FSM with registered Avalon outputs and the credit counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= POLL_REQ;
      csr_read       <= 1'b0;
      fifo_write     <= 1'b0;
      fifo_writedata <= '0;
      credit         <= 9'd0;
      bo_cnt_r       <= '0;
    end else begin
      case (state_r)
        POLL_REQ: begin
          // Entered with csr_read low only straight out of reset.
          if (csr_read) begin
            csr_read <= 1'b0;
            state_r  <= POLL_WAIT;
          end else begin
            csr_read <= 1'b1;
          end
        end
        POLL_WAIT: begin
          credit <= poll_credit_s;
          if (poll_credit_s != 9'd0) begin
            state_r <= IDLE;
          end else begin
            bo_cnt_r <= '0;
            state_r  <= BACKOFF;
          end
        end
        IDLE: begin
          if (count_r != '0) begin
            if (credit != 9'd0) begin
              fifo_write     <= 1'b1;
              fifo_writedata <= head_s;
              state_r        <= WRITE;
            end else begin
              csr_read <= 1'b1;
              state_r  <= POLL_REQ;
            end
          end
        end
        WRITE: begin
          if (!fifo_waitrequest) begin
            credit <= credit - 9'd1;
            if (more_s && (credit > 9'd1)) begin
              fifo_writedata <= next_head_s;
            end else begin
              fifo_write <= 1'b0;
              state_r    <= IDLE;
            end
          end
        end
        BACKOFF: begin
          if (bo_cnt_r == BO_LAST) begin
            csr_read <= 1'b1;
            state_r  <= POLL_REQ;
          end else begin
            bo_cnt_r <= bo_cnt_r + 1'b1;
          end
        end
        default: begin
          csr_read   <= 1'b0;
          fifo_write <= 1'b0;
          state_r    <= POLL_REQ;
        end
      endcase
    end
  end

`ifdef FIFO_IN_WRITER_STATS_EN
  // Completed-write and waitrequest-stall counters, both free-running and wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      words_written <= 32'd0;
      stall_cycles  <= 32'd0;
    end else begin
      if (pop_s) begin
        words_written <= words_written + 32'd1;
      end
      if (fifo_write && fifo_waitrequest) begin
        stall_cycles <= stall_cycles + 32'd1;
      end
    end
  end
`endif

endmodule
